keypad_matrix_emulator: RTL and testbench

Synthesizable model of the far end of the 4x4 keypad matrix protocol. It observes the active-low column lines driven by a keypad scanner and returns active-low row lines as if a human were pressing keys. Key codes are queued from a host-side valid/ready interface and played back with programmable contact bounce, hold time and inter-key gap. It serves as the board-level loopback and simulation stimulus for the keypad scanner path.

---
 rtl/keypad_matrix_emulator.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
//
// Emulates the key side of a 4x4 active-low keypad matrix. Key codes are
// queued from a host valid/ready interface and played back one at a time as
// press bounce, clean hold, release bounce and a clean gap. While the
// emulated contact is closed, the row of the active key is pulled low
// whenever the scanner drives that key's column low.
//
// Key map (row / column):
//   R1: 1 2 3 A   R2: 4 5 6 B   R3: 7 8 9 C   R4: 0 F E D
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   col_n[3:0] scanner column lines, active low (bit 3 = column 1)
//   row_n[3:0] emulated row lines, active low (bit 3 = row 1), registered
//   key_code   hex value of the key to queue
//   key_valid  key_code is valid
//   key_ready  queue has room; transfer on key_valid && key_ready
//   contact    emulated switch closed (registered)
//   busy       FSM not idle, or keys still queued
//   key_done   one-cycle pulse in the last cycle of a key's gap phase
module keypad_matrix_emulator #(
    parameter int FIFO_DEPTH    = 4,
    parameter int BOUNCE_CYCLES = 100000,
    parameter int BOUNCE_TOGGLE = 10000,
    parameter int HOLD_CYCLES   = 5000000,
    parameter int GAP_CYCLES    = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       contact,
    output logic       busy,
    output logic       key_done
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT  = FIFO_DEPTH[AW:0];
    localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
    localparam logic [31:0] BOUNCE_LAST = 32'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [31:0] TOGGLE_LAST = 32'(BOUNCE_TOGGLE - 1);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        REL_BOUNCE,
        GAP
    } state_t;

    // Returns {row mask, column mask}, one-hot, bit 3 = row/column 1.
    function automatic logic [7:0] key_lines(input logic [3:0] k);
        case (k)
            4'h1:    key_lines = {4'b1000, 4'b1000};
            4'h2:    key_lines = {4'b1000, 4'b0100};
            4'h3:    key_lines = {4'b1000, 4'b0010};
            4'hA:    key_lines = {4'b1000, 4'b0001};
            4'h4:    key_lines = {4'b0100, 4'b1000};
            4'h5:    key_lines = {4'b0100, 4'b0100};
            4'h6:    key_lines = {4'b0100, 4'b0010};
            4'hB:    key_lines = {4'b0100, 4'b0001};
            4'h7:    key_lines = {4'b0010, 4'b1000};
            4'h8:    key_lines = {4'b0010, 4'b0100};
            4'h9:    key_lines = {4'b0010, 4'b0010};
            4'hC:    key_lines = {4'b0010, 4'b0001};
            4'hF:    key_lines = {4'b0001, 4'b0100};
            4'hE:    key_lines = {4'b0001, 4'b0010};
            4'hD:    key_lines = {4'b0001, 4'b0001};
            default: key_lines = {4'b0001, 4'b1000};  // key 0
        endcase
    endfunction

    // ---- key queue ----
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // key_ready looks only at count, so a full queue refuses a push even in
    // a cycle where the FSM pops.
    assign key_ready = (count != FULL_COUNT);
    assign push      = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= key_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- playback FSM ----
    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] tcnt;
    logic [31:0] tcnt_nxt;
    logic        contact_nxt;
    logic [3:0]  active_key;

    // contact is computed alongside the next state so that the registered
    // value always belongs to the state it is registered with.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 32'd1;
        tcnt_nxt    = tcnt;
        contact_nxt = contact;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                tcnt_nxt    = '0;
                contact_nxt = 1'b0;
                if (count != '0) begin
                    pop         = 1'b1;
                    contact_nxt = 1'b1;
                    if (HAS_BOUNCE) begin
                        state_nxt = PRESS_BOUNCE;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            PRESS_BOUNCE, REL_BOUNCE: begin
                if (cnt == BOUNCE_LAST) begin
                    cnt_nxt  = '0;
                    tcnt_nxt = '0;
                    if (state == PRESS_BOUNCE) begin
                        state_nxt   = HOLD;
                        contact_nxt = 1'b1;
                    end else begin
                        state_nxt   = GAP;
                        contact_nxt = 1'b0;
                    end
                end else if (tcnt == TOGGLE_LAST) begin
                    tcnt_nxt    = '0;
                    contact_nxt = ~contact;
                end else begin
                    tcnt_nxt = tcnt + 32'd1;
                end
            end
            HOLD: begin
                contact_nxt = 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_nxt     = '0;
                    tcnt_nxt    = '0;
                    contact_nxt = 1'b0;
                    if (HAS_BOUNCE) begin
                        state_nxt = REL_BOUNCE;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                contact_nxt = 1'b0;
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                tcnt_nxt    = '0;
                contact_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tcnt       <= '0;
            contact    <= 1'b0;
            active_key <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tcnt    <= tcnt_nxt;
            contact <= contact_nxt;
            if (pop) begin
                active_key <= fifo_mem[rd_ptr];
            end
        end
    end

    assign key_done = (state == GAP) && (cnt == GAP_LAST);
    assign busy     = (state != IDLE) || (count != '0);

    // ---- row drive ----
    logic [7:0] lines;
    logic       col_hit;

    assign lines   = key_lines(active_key);
    // Any low column matching the key's column pulls its row low.
    assign col_hit = |(lines[3:0] & ~col_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_n <= 4'hF;
        end else if (contact && col_hit) begin
            row_n <= ~lines[7:4];
        end else begin
            row_n <= 4'hF;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator. Two instances run side by side:
// dut_a without bounce (hold 20, gap 10) and dut_b with bounce 8 / toggle 2
// (hold 6, gap 4). Inputs are driven 1 time unit after the rising edge and
// outputs are read at the same point.
module tb_keypad_matrix_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       a_rst, a_valid, a_ready, a_contact, a_busy, a_done;
    logic [3:0] a_col, a_row, a_key;
    logic       b_rst, b_valid, b_ready, b_contact, b_busy, b_done;
    logic [3:0] b_col, b_row, b_key;

    keypad_matrix_emulator #(
        .FIFO_DEPTH(4), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1),
        .HOLD_CYCLES(20), .GAP_CYCLES(10)
    ) dut_a (
        .clk(clk), .rst(a_rst), .col_n(a_col), .row_n(a_row),
        .key_code(a_key), .key_valid(a_valid), .key_ready(a_ready),
        .contact(a_contact), .busy(a_busy), .key_done(a_done)
    );

    keypad_matrix_emulator #(
        .FIFO_DEPTH(4), .BOUNCE_CYCLES(8), .BOUNCE_TOGGLE(2),
        .HOLD_CYCLES(6), .GAP_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .col_n(b_col), .row_n(b_row),
        .key_code(b_key), .key_valid(b_valid), .key_ready(b_ready),
        .contact(b_contact), .busy(b_busy), .key_done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_col = 4'b1110; b_col = 4'b1110;
        a_key = 4'h0; b_key = 4'h0;
        a_valid = 1'b0; b_valid = 1'b0;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;
        step(); step();
        n_checks++; if (a_row !== 4'hF) $display("FAIL reset_a_row: got %h want f", a_row); else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_ready); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_a_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_contact !== 1'b0) $display("FAIL reset_a_contact: got %b want 0", a_contact); else n_pass++;
        n_checks++; if (a_done !== 1'b0) $display("FAIL reset_a_done: got %b want 0", a_done); else n_pass++;
        n_checks++; if (b_row !== 4'hF) $display("FAIL reset_b_row: got %h want f", b_row); else n_pass++;
        n_checks++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_ready); else n_pass++;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL reset_b_busy: got %b want 0", b_busy); else n_pass++;
    endtask

    // Key 5 (row 2 / column 2) with a scanner walking the columns, 4 clk each.
    // Contact closes the edge after the push edge, holds 20 cycles, then the
    // 10 gap cycles follow; key_done is high in the last of them (j = 30).
    task automatic test_scan();
        logic [3:0] cols [4];
        logic [3:0] col_now, exp_row;
        logic       exp_c, exp_done, exp_busy, prev_c;
        cols[0] = 4'b0111; cols[1] = 4'b1011; cols[2] = 4'b1101; cols[3] = 4'b1110;
        a_key = 4'h5; a_valid = 1'b1; a_col = cols[0];
        step();
        a_valid = 1'b0;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL scan_busy_after_push: got %b want 1", a_busy); else n_pass++;
        prev_c = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            col_now = cols[(j / 4) % 4];
            a_col = col_now;
            step();
            exp_c    = (j >= 1) && (j <= 20);
            exp_row  = (prev_c && col_now == 4'b1011) ? 4'b1011 : 4'hF;
            exp_done = (j == 30);
            exp_busy = (j <= 30);
            n_checks++; if (a_contact !== exp_c) $display("FAIL scan_contact j=%0d: got %b want %b", j, a_contact, exp_c); else n_pass++;
            n_checks++; if (a_row !== exp_row) $display("FAIL scan_row j=%0d: got %b want %b", j, a_row, exp_row); else n_pass++;
            n_checks++; if (a_done !== exp_done) $display("FAIL scan_done j=%0d: got %b want %b", j, a_done, exp_done); else n_pass++;
            n_checks++; if (a_busy !== exp_busy) $display("FAIL scan_busy j=%0d: got %b want %b", j, a_busy, exp_busy); else n_pass++;
            prev_c = exp_c;
        end
    endtask

    // Key D (row 4 / column 4), col_n = 1110. Press bounce 1,1,0,0,1,1,0,0
    // (j 1..8), hold j 9..14, release bounce 0,0,1,1,0,0,1,1 (j 15..22),
    // gap j 23..26 with key_done at j 26.
    task automatic test_bounce();
        logic [3:0] exp_row;
        logic       exp_c, exp_done, prev_c;
        b_key = 4'hD; b_valid = 1'b1; b_col = 4'b1110;
        step();
        b_valid = 1'b0;
        prev_c = 1'b0;
        for (int j = 1; j <= 28; j++) begin
            step();
            if (j <= 8)       exp_c = (((j - 1) / 2) % 2) == 0;
            else if (j <= 14) exp_c = 1'b1;
            else if (j <= 22) exp_c = (((j - 15) / 2) % 2) == 1;
            else              exp_c = 1'b0;
            exp_row  = prev_c ? 4'b1110 : 4'hF;
            exp_done = (j == 26);
            n_checks++; if (b_contact !== exp_c) $display("FAIL bounce_contact j=%0d: got %b want %b", j, b_contact, exp_c); else n_pass++;
            n_checks++; if (b_row !== exp_row) $display("FAIL bounce_row j=%0d: got %b want %b", j, b_row, exp_row); else n_pass++;
            n_checks++; if (b_done !== exp_done) $display("FAIL bounce_done j=%0d: got %b want %b", j, b_done, exp_done); else n_pass++;
            prev_c = exp_c;
        end
    endtask

    // Key 1 (row 1 / column 1) with several columns low at once.
    task automatic test_multi_col();
        int w;
        a_key = 4'h1; a_valid = 1'b1; a_col = 4'hF;
        step();
        a_valid = 1'b0;
        step();
        n_checks++; if (a_contact !== 1'b1) $display("FAIL multi_contact: got %b want 1", a_contact); else n_pass++;
        a_col = 4'b0110; step();
        n_checks++; if (a_row !== 4'b0111) $display("FAIL multi_0110: got %b want 0111", a_row); else n_pass++;
        a_col = 4'b1111; step();
        n_checks++; if (a_row !== 4'hF) $display("FAIL multi_1111: got %b want 1111", a_row); else n_pass++;
        a_col = 4'b1001; step();
        n_checks++; if (a_row !== 4'hF) $display("FAIL multi_1001: got %b want 1111", a_row); else n_pass++;
        a_col = 4'b0000; step();
        n_checks++; if (a_row !== 4'b0111) $display("FAIL multi_0000: got %b want 0111", a_row); else n_pass++;
        a_col = 4'hF;
        w = 0;
        while (a_done !== 1'b1 && w < 40) begin step(); w++; end
        n_checks++; if (a_done !== 1'b1) $display("FAIL multi_done: got %b want 1 (timeout)", a_done); else n_pass++;
        step();
        n_checks++; if (a_busy !== 1'b0) $display("FAIL multi_idle_busy: got %b want 0", a_busy); else n_pass++;
    endtask

    // Leader key 4 is popped at once; keys 1,2,3,A then fill the queue and
    // key 0 stalls until key 1 is popped, 24 cycles after the queue filled.
    task automatic test_back_to_back();
        logic [3:0] col_exp [5];
        logic [3:0] row_exp [5];
        int stall, leader_done, w;
        col_exp[0] = 4'b0111; row_exp[0] = 4'b0111;  // 1
        col_exp[1] = 4'b1011; row_exp[1] = 4'b0111;  // 2
        col_exp[2] = 4'b1101; row_exp[2] = 4'b0111;  // 3
        col_exp[3] = 4'b1110; row_exp[3] = 4'b0111;  // A
        col_exp[4] = 4'b0111; row_exp[4] = 4'b1110;  // 0
        b_col = 4'hF;
        b_key = 4'h4; b_valid = 1'b1; step();
        b_key = 4'h1; step();
        b_key = 4'h2; step();
        b_key = 4'h3; step();
        b_key = 4'hA; step();
        n_checks++; if (b_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", b_ready); else n_pass++;
        b_key = 4'h0;
        stall = 0; leader_done = 0;
        while (b_ready !== 1'b1 && stall < 100) begin
            step(); stall++;
            if (b_done === 1'b1) leader_done++;
        end
        n_checks++; if (stall != 24) $display("FAIL b2b_stall_cycles: got %0d want 24", stall); else n_pass++;
        n_checks++; if (leader_done != 1) $display("FAIL b2b_leader_done: got %0d want 1", leader_done); else n_pass++;
        step();
        b_valid = 1'b0;
        n_checks++; if (b_ready !== 1'b0) $display("FAIL b2b_refull_ready: got %b want 0", b_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (b_contact !== 1'b1 && w < 60) begin step(); w++; end
            n_checks++; if (b_contact !== 1'b1) $display("FAIL b2b_press_%0d: got %b want 1 (timeout)", k, b_contact); else n_pass++;
            b_col = col_exp[k];
            repeat (10) step();
            n_checks++; if (b_row !== row_exp[k]) $display("FAIL b2b_row_%0d: got %b want %b", k, b_row, row_exp[k]); else n_pass++;
            b_col = 4'hF;
            w = 0;
            while (b_done !== 1'b1 && w < 60) begin step(); w++; end
            n_checks++; if (b_done !== 1'b1) $display("FAIL b2b_done_%0d: got %b want 1 (timeout)", k, b_done); else n_pass++;
        end
        step();
        n_checks++; if (b_busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", b_busy); else n_pass++;
        n_checks++; if (b_ready !== 1'b1) $display("FAIL b2b_end_ready: got %b want 1", b_ready); else n_pass++;
    endtask

    // Key 9 (row 3 / column 3) in HOLD with keys 3 and 7 queued, then reset.
    task automatic test_reset_mid();
        int done_seen, contact_seen;
        a_col = 4'b1101;
        a_key = 4'h9; a_valid = 1'b1; step();
        a_key = 4'h3; step();
        a_key = 4'h7; step();
        a_valid = 1'b0;
        step(); step();
        n_checks++; if (a_row !== 4'b1101) $display("FAIL midrst_pre_row: got %b want 1101", a_row); else n_pass++;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b want 1", a_busy); else n_pass++;
        a_rst = 1'b1;
        step();
        n_checks++; if (a_contact !== 1'b0) $display("FAIL midrst_contact: got %b want 0", a_contact); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", a_ready); else n_pass++;
        a_rst = 1'b0;
        step();
        n_checks++; if (a_row !== 4'hF) $display("FAIL midrst_row: got %b want 1111", a_row); else n_pass++;
        done_seen = 0; contact_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_done === 1'b1) done_seen++;
            if (a_contact === 1'b1) contact_seen++;
        end
        n_checks++; if (done_seen != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); else n_pass++;
        n_checks++; if (contact_seen != 0) $display("FAIL midrst_no_contact: got %0d cycles want 0", contact_seen); else n_pass++;
        n_checks++; if (a_row !== 4'hF) $display("FAIL midrst_row_after: got %b want 1111", a_row); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_bounce();
        test_multi_col();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
